// File: rtl/perf_monitor_if.sv
// Status/readback bundle between the core-side probe and perf_monitor.
// master drives the sampled core status and read address; slave returns the read data and the done flag.
interface perf_monitor_if #(
  parameter int CNT_WIDTH = 32
);
  logic [31:0]          inst;
  logic                 stall;
  logic                 flush;
  logic                 branch_flush;
  logic                 bht_access;
  logic                 bht_correct;
  logic [2:0]           rd_addr;
  logic [CNT_WIDTH-1:0] rd_data;
  logic                 done;

  modport master (
    output inst, stall, flush, branch_flush, bht_access, bht_correct, rd_addr,
    input  rd_data, done
  );

  modport slave (
    input  inst, stall, flush, branch_flush, bht_access, bht_correct, rd_addr,
    output rd_data, done
  );
endinterface

// File: rtl/perf_monitor.sv
// perf_monitor: saturating performance counters plus end-of-program detection (NOP run or repeated fetch).
// Optional BHT access/correct counters are built only when PERF_BHT_EN is defined; reads are registered.
module perf_monitor #(
  parameter int CNT_WIDTH    = 32,
  parameter int REPEAT_LIMIT = 49,
  parameter int NOP_LIMIT    = 8
) (
  input  logic          CLK,
  input  logic          rst,
  perf_monitor_if.slave bus
);
  localparam int RUN_MAX = (REPEAT_LIMIT > NOP_LIMIT) ? REPEAT_LIMIT : NOP_LIMIT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  function automatic cnt_t sat_add(input cnt_t a, input logic [1:0] inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  logic [31:0]      r_last_inst;
  logic [RUN_W-1:0] r_nop_run;
  logic [RUN_W-1:0] r_rep_run;
  logic             r_done;
  logic [1:0]       r_reason;
  cnt_t             r_cycles;
  cnt_t             r_stall_cyc;
  cnt_t             r_stall_run;
  cnt_t             r_stall_max;
  cnt_t             r_flush_cyc;
  cnt_t             r_nops;
  cnt_t             r_rd_data;

  logic             w_is_nop;
  logic             w_same;
  logic [RUN_W-1:0] w_nop_run_nxt;
  logic [RUN_W-1:0] w_rep_run_nxt;
  logic             w_hit_nop;
  logic             w_hit_rep;
  logic [1:0]       w_flush_inc;
  cnt_t             w_stall_run_inc;
  cnt_t             w_bht_acc;
  cnt_t             w_bht_ok;
  cnt_t             w_rd_mux;

  assign w_is_nop = (bus.inst[15:0] == 16'h0001) || (bus.inst == 32'h0000_0013);
  assign w_same   = (bus.inst == r_last_inst);

  always_comb begin
    w_nop_run_nxt = '0;
    w_rep_run_nxt = '0;
    if (w_same) begin
      w_rep_run_nxt = r_rep_run + RUN_W'(1);
      w_nop_run_nxt = w_is_nop ? r_nop_run + RUN_W'(1) : r_nop_run;
    end
  end

  assign w_hit_nop       = (w_nop_run_nxt == RUN_W'(NOP_LIMIT));
  assign w_hit_rep       = (w_rep_run_nxt == RUN_W'(REPEAT_LIMIT));
  // flush already covers the 1-cycle penalty when both fire together
  assign w_flush_inc     = bus.flush ? 2'd1 : (bus.branch_flush ? 2'd2 : 2'd0);
  assign w_stall_run_inc = sat_add(r_stall_run, 2'd1);

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_last_inst <= '0;
      r_nop_run   <= '0;
      r_rep_run   <= '0;
      r_done      <= 1'b0;
      r_reason    <= '0;
      r_cycles    <= '0;
      r_stall_cyc <= '0;
      r_stall_run <= '0;
      r_stall_max <= '0;
      r_flush_cyc <= '0;
      r_nops      <= '0;
      r_rd_data   <= '0;
    end else begin
      r_rd_data <= w_rd_mux;
      if (!r_done) begin
        if (!w_same) r_last_inst <= bus.inst;
        r_nop_run <= w_nop_run_nxt;
        r_rep_run <= w_rep_run_nxt;
        if (w_hit_nop || w_hit_rep) begin
          r_done   <= 1'b1;
          r_reason <= {w_hit_rep, w_hit_nop};
        end
        r_cycles    <= sat_add(r_cycles, 2'd1);
        r_stall_cyc <= sat_add(r_stall_cyc, {1'b0, bus.stall});
        r_stall_run <= bus.stall ? w_stall_run_inc : '0;
        if (bus.stall && (w_stall_run_inc > r_stall_max)) r_stall_max <= w_stall_run_inc;
        r_flush_cyc <= sat_add(r_flush_cyc, w_flush_inc);
        r_nops      <= sat_add(r_nops, {1'b0, w_is_nop});
      end
    end
  end

`ifdef PERF_BHT_EN
  cnt_t r_bht_acc;
  cnt_t r_bht_ok;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_bht_acc <= '0;
      r_bht_ok  <= '0;
    end else if (!r_done) begin
      r_bht_acc <= sat_add(r_bht_acc, {1'b0, bus.bht_access});
      r_bht_ok  <= sat_add(r_bht_ok, {1'b0, bus.bht_correct});
    end
  end

  assign w_bht_acc = r_bht_acc;
  assign w_bht_ok  = r_bht_ok;
`else
  logic w_unused_bht;
  assign w_unused_bht = bus.bht_access ^ bus.bht_correct;
  assign w_bht_acc    = '0;
  assign w_bht_ok     = '0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (bus.rd_addr)
      3'd0:    w_rd_mux = r_cycles;
      3'd1:    w_rd_mux = r_stall_cyc;
      3'd2:    w_rd_mux = r_flush_cyc;
      3'd3:    w_rd_mux = r_nops;
      3'd4:    w_rd_mux = w_bht_acc;
      3'd5:    w_rd_mux = w_bht_ok;
      3'd6:    w_rd_mux = {{(CNT_WIDTH-3){1'b0}}, r_reason, r_done};
      3'd7:    w_rd_mux = r_stall_max;
      default: w_rd_mux = '0;
    endcase
  end

  assign bus.rd_data = r_rd_data;
  assign bus.done    = r_done;
endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a 32-bit instance for detection/counting and a 4-bit instance for saturation.
module tb_perf_monitor;
  logic CLK = 1'b0;
  logic rst;
  logic rst_s;
  int   tests = 0;
  int   fails = 0;

  logic [12:0] st_pat;
  logic [12:0] fl_pat;
  logic [12:0] bf_pat;
  logic [12:0] ba_pat;
  logic [12:0] bc_pat;
  logic [31:0] exp_acc;
  logic [31:0] exp_ok;

  perf_monitor_if #(.CNT_WIDTH(32)) mon ();
  perf_monitor_if #(.CNT_WIDTH(4))  mon_s ();

  perf_monitor #(.CNT_WIDTH(32)) u_dut (.CLK(CLK), .rst(rst),   .bus(mon));
  perf_monitor #(.CNT_WIDTH(4))  u_sat (.CLK(CLK), .rst(rst_s), .bus(mon_s));

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_main(input logic [2:0] addr, input string tag, input logic [31:0] exp);
    mon.rd_addr = addr;
    step();
    check(tag, mon.rd_data, exp);
  endtask

  task automatic read_sat(input logic [2:0] addr, input string tag, input logic [31:0] exp);
    mon_s.rd_addr = addr;
    step();
    check(tag, 32'(mon_s.rd_data), exp);
  endtask

  task automatic idle_main();
    mon.stall = 1'b0; mon.flush = 1'b0; mon.branch_flush = 1'b0;
    mon.bht_access = 1'b0; mon.bht_correct = 1'b0; mon.rd_addr = 3'd0;
  endtask

  initial begin
`ifdef PERF_BHT_EN
    exp_acc = 32'd6; exp_ok = 32'd4;
`else
    exp_acc = 32'd0; exp_ok = 32'd0;
`endif
    st_pat = 13'h039F; fl_pat = 13'h0400; bf_pat = 13'h1C00;
    ba_pat = 13'h003F; bc_pat = 13'h000F;

    rst = 1'b1; rst_s = 1'b1;
    idle_main();
    mon.inst = 32'h0000_0013;
    mon_s.inst = 32'h0; mon_s.stall = 1'b0; mon_s.flush = 1'b0; mon_s.branch_flush = 1'b0;
    mon_s.bht_access = 1'b0; mon_s.bht_correct = 1'b0; mon_s.rd_addr = 3'd0;
    step(); step();
    check("rst_done", 32'(mon.done), 32'd0);
    check("rst_rd_data", mon.rd_data, 32'd0);
    check("rst_done_sat", 32'(mon_s.done), 32'd0);

    // Constant NOP: done on edge 9
    rst = 1'b0;
    repeat (8) step();
    check("nop_not_yet", 32'(mon.done), 32'd0);
    step();
    check("nop_done", 32'(mon.done), 32'd1);
    read_main(3'd0, "nop_cycles", 32'd9);
    read_main(3'd3, "nop_nops", 32'd9);
    read_main(3'd6, "nop_status", 32'h3);
    read_main(3'd1, "nop_stall", 32'd0);
    read_main(3'd0, "nop_frozen", 32'd9);

    // Self-jump: done on edge 50
    rst = 1'b1;
    mon.inst = 32'h0000_006F;
    step();
    rst = 1'b0;
    check("rep_rst_clear", 32'(mon.done), 32'd0);
    repeat (49) step();
    check("rep_not_yet", 32'(mon.done), 32'd0);
    step();
    check("rep_done", 32'(mon.done), 32'd1);
    read_main(3'd0, "rep_cycles", 32'd50);
    read_main(3'd3, "rep_nops", 32'd0);
    read_main(3'd6, "rep_status", 32'h5);

    // Stall runs, flush penalties and BHT pulses, then terminate with NOPs
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      mon.inst         = 32'h1000 + 32'(i);
      mon.stall        = st_pat[i];
      mon.flush        = fl_pat[i];
      mon.branch_flush = bf_pat[i];
      mon.bht_access   = ba_pat[i];
      mon.bht_correct  = bc_pat[i];
      step();
    end
    idle_main();
    mon.inst = 32'h0000_0013;
    for (int k = 0; k < 30 && !mon.done; k++) step();
    check("mix_done", 32'(mon.done), 32'd1);
    read_main(3'd0, "mix_cycles", 32'd22);
    read_main(3'd1, "mix_stall_cyc", 32'd8);
    read_main(3'd7, "mix_stall_max", 32'd5);
    read_main(3'd2, "mix_flush_cyc", 32'd5);
    read_main(3'd3, "mix_nops", 32'd9);
    read_main(3'd4, "mix_bht_acc", exp_acc);
    read_main(3'd5, "mix_bht_ok", exp_ok);
    read_main(3'd6, "mix_status", 32'h3);

    // 4-bit counters: saturate, never wrap
    mon_s.stall = 1'b1;
    mon_s.branch_flush = 1'b1;
    mon_s.rd_addr = 3'd1;
    rst_s = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mon_s.inst = 32'h200 + 32'(i);
      step();
    end
    check("sat_stall_cyc", 32'(mon_s.rd_data), 32'd15);
    read_sat(3'd0, "sat_cycles", 32'd15);
    read_sat(3'd2, "sat_flush_cyc", 32'd15);
    read_sat(3'd7, "sat_stall_max", 32'd15);
    read_sat(3'd6, "sat_status", 32'd0);

    // Mid-run reset clears everything; counting resumes afterward
    rst_s = 1'b1;
    step();
    check("sat_rst_rd", 32'(mon_s.rd_data), 32'd0);
    rst_s = 1'b0;
    mon_s.stall = 1'b0;
    mon_s.branch_flush = 1'b0;
    read_sat(3'd1, "sat_rst_stall", 32'd0);
    read_sat(3'd2, "sat_rst_flush", 32'd0);
    read_sat(3'd7, "sat_rst_smax", 32'd0);
    read_sat(3'd3, "sat_rst_nops", 32'd0);
    read_sat(3'd0, "sat_rst_cycles", 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
